// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 16x oversample tick generated as a clock enable.
// Bytes are handed to the consumer on a valid/ack handshake with error flags.
module uart_rx #(
  parameter int CLK_DIV   = 326,
  parameter int DATA_BITS = 8
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BREAK
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [3:0]           smp_cnt_q, smp_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 sync1_q, sync2_q;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 tick;
  logic                 rx_s;
  logic                 good;

  assign rx_s = sync2_q;
  assign tick = (tick_cnt_q == TW'(CLK_DIV - 1));

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    state_d    = state_q;
    smp_cnt_d  = smp_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ferr_d     = 1'b0;
    good       = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d   = START;
            smp_cnt_d = '0;
          end
        end
        START: begin
          if (smp_cnt_q == 4'd7) begin
            smp_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = rx_s ? IDLE : DATA;
          end else begin
            smp_cnt_d = smp_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (smp_cnt_q == 4'd15) begin
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            smp_cnt_d = '0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 4'(DATA_BITS - 1)) state_d = STOP;
          end else begin
            smp_cnt_d = smp_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (smp_cnt_q == 4'd15) begin
            smp_cnt_d = '0;
            if (rx_s) begin
              good    = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end else begin
            smp_cnt_d = smp_cnt_q + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame load beats a coincident ack; overrun only when the old byte was unread.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (rx_ack && valid_q) valid_d = 1'b0;
    if (good) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !rx_ack) ovr_d = 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      smp_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      smp_cnt_q  <= smp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign framing_err = ferr_q;
  assign overrun_err = ovr_q;
  assign busy        = busy_q;

endmodule
